vend_ctrl_param: RTL

Parametrised vending controller. It accepts two coin denominations, accumulates credit, and checks it against a programmable per-product price table. It dispenses the selected product, then returns change one coin per cycle, largest denomination first. It replaces the fixed-width FSM/counter/register/comparator chain with one configurable block. It adds cancel/refund, overflow rejection and an insufficient-credit indication.

---
 rtl/vend_ctrl_param.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: coin credit, price-table vend, largest-first change.
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC idle cycles in COLLECT.
module vend_ctrl_param #(
  parameter int NUM_PROD    = 8,
  parameter int SEL_W       = 3,
  parameter int CREDIT_W    = 6,
  parameter int COIN1_VAL   = 1,
  parameter int COIN2_VAL   = 5,
  parameter int MAX_CREDIT  = 50,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         M1,
  input  logic                         M2,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         vend_req,
  input  logic                         cancel,
  input  logic [NUM_PROD*CREDIT_W-1:0] price,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         dispense,
  output logic [SEL_W-1:0]             bebida,
  output logic                         chg1,
  output logic                         chg2,
  output logic                         coin_rej,
  output logic                         insuf,
  output logic [1:0]                   state
);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} state_t;

  localparam int XW = CREDIT_W + 1;
  localparam logic [XW-1:0]       C1X  = XW'(COIN1_VAL);
  localparam logic [XW-1:0]       C2X  = XW'(COIN2_VAL);
  localparam logic [XW-1:0]       MAXX = XW'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] C1W  = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W-1:0] C2W  = CREDIT_W'(COIN2_VAL);
  localparam logic [CREDIT_W-1:0] MAXW = CREDIT_W'(MAX_CREDIT);

  if (COIN2_VAL <= COIN1_VAL || (COIN2_VAL % COIN1_VAL) != 0 ||
      MAX_CREDIT >= 2**CREDIT_W || TIMEOUT_CYC < 1 || NUM_PROD > 2**SEL_W) begin : g_bad_params
    $error("vend_ctrl_param: inconsistent parameters");
  end

  state_t st;
  assign state = st;

  logic [CREDIT_W-1:0] price_sel, price_vend, remain, refund_src, refund_next, credit_acc;
  logic [XW-1:0]       coin_v, sum;
  logic                sel_ok, coin_ok, coin_rej_c, refund_big, tmo_exp;

  always_comb begin
    price_sel  = '0;
    price_vend = '0;
    sel_ok     = 1'b0;
    for (int k = 0; k < NUM_PROD; k++) begin
      if (sel == SEL_W'(k)) begin
        price_sel = price[k*CREDIT_W +: CREDIT_W];
        sel_ok    = 1'b1;
      end
      if (bebida == SEL_W'(k)) price_vend = price[k*CREDIT_W +: CREDIT_W];
    end
  end

  // M2 wins a simultaneous insertion; the M1 coin is always bounced in that case.
  always_comb begin
    coin_v     = M2 ? C2X : (M1 ? C1X : '0);
    sum        = {1'b0, credit} + coin_v;
    coin_ok    = (st == IDLE || st == COLLECT) && (M1 || M2) && (sum <= MAXX);
    coin_rej_c = (M1 && M2) || ((M1 || M2) && !coin_ok);
    credit_acc = coin_ok ? sum[CREDIT_W-1:0] : credit;
  end

  // One change coin per cycle; the first coin is issued on the edge that enters CHANGE.
  always_comb begin
    remain      = (credit > price_vend) ? credit - price_vend : '0;
    refund_src  = (st == VEND) ? remain : ((st == CHANGE) ? credit : credit_acc);
    refund_big  = refund_src >= C2W;
    refund_next = refund_big ? refund_src - C2W :
                  ((refund_src >= C1W) ? refund_src - C1W : '0);
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk) begin
    if (rst || st != COLLECT || coin_ok || vend_req) tmo_q <= TW'(TIMEOUT_CYC - 1);
    else if (tmo_q != '0)                            tmo_q <= tmo_q - 1'b1;
  end

  assign tmo_exp = (st == COLLECT) && (tmo_q == '0) && !coin_ok && !vend_req;
`else
  assign tmo_exp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      credit   <= '0;
      bebida   <= '0;
      dispense <= 1'b0;
      chg1     <= 1'b0;
      chg2     <= 1'b0;
      coin_rej <= 1'b0;
      insuf    <= 1'b0;
    end else begin
      dispense <= 1'b0;
      chg1     <= 1'b0;
      chg2     <= 1'b0;
      insuf    <= 1'b0;
      coin_rej <= coin_rej_c;
      case (st)
        IDLE: begin
          credit <= credit_acc;
          if (coin_ok)  st    <= COLLECT;
          if (vend_req) insuf <= 1'b1;
        end
        COLLECT: begin
          if (cancel || tmo_exp) begin
            if (credit_acc == '0) begin
              st     <= IDLE;
              credit <= '0;
            end else begin
              st     <= CHANGE;
              credit <= refund_next;
              chg2   <= refund_big;
              chg1   <= !refund_big;
            end
          end else if (vend_req && (!sel_ok || credit < price_sel)) begin
            insuf  <= 1'b1;
            credit <= credit_acc;
          end else if (vend_req) begin
            st       <= VEND;
            bebida   <= sel;
            dispense <= 1'b1;
            credit   <= credit_acc;
          end else begin
            credit <= credit_acc;
          end
        end
        VEND: begin
          if (remain == '0) begin
            st     <= IDLE;
            credit <= '0;
          end else begin
            st     <= CHANGE;
            credit <= refund_next;
            chg2   <= refund_big;
            chg1   <= !refund_big;
          end
        end
        CHANGE: begin
          if (vend_req) insuf <= 1'b1;
          if (credit == '0) begin
            st <= IDLE;
          end else begin
            credit <= refund_next;
            chg2   <= refund_big;
            chg1   <= !refund_big;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  a_credit_max: assert property (@(posedge clk) disable iff (rst) credit <= MAXW);

endmodule
